// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared encodings and decode helpers for the RRISC sequencer
package ctrl_seq_pkg;
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_LOADIR, S_DECODE, S_EXEC, S_MEMADDR,
    S_MEM, S_WB, S_BRANCH, S_HALT, S_TRAP
  } state_e;
  typedef enum logic [1:0] {MEM_NONE, MEM_READ, MEM_WRITE} mem_cmd_e;
  typedef enum logic [1:0] {PC_INC, PC_RST, PC_REL, PC_RD} pc_src_e;
  typedef enum logic [1:0] {V_MDATA, V_IMM8, V_PC, V_C} vsel_e;
  typedef enum logic [2:0] {C_AL, C_EQ, C_NE, C_LT, C_LE, C_GE, C_GT, C_NV} cond_e;
  typedef enum logic [3:0] {
    K_ALU, K_CMP, K_MOV, K_MOVI, K_LDR, K_STR, K_B, K_BL, K_BLX, K_BX, K_HALT, K_ILL
  } op_e;
  localparam logic [2:0] OP_B = 3'b001, OP_LINK = 3'b010, OP_LDR = 3'b011, OP_STR = 3'b100;
  localparam logic [2:0] OP_ALU = 3'b101, OP_MOV = 3'b110, OP_HLT = 3'b111;
  localparam logic [1:0] AL_CMP = 2'b01, MV_REG = 2'b00, MV_IMM = 2'b10;
  localparam logic [1:0] BR_BX = 2'b00, BR_BLX = 2'b10, BR_BL = 2'b11;
  // Collapse {opcode,aluop} into one instruction class; unlisted encodings are illegal
  function automatic op_e classify(input logic [2:0] op, input logic [1:0] au);
    case (op)
      OP_B: return K_B;
      OP_LINK: return au == BR_BL ? K_BL : au == BR_BLX ? K_BLX : au == BR_BX ? K_BX : K_ILL;
      OP_LDR: return K_LDR;
      OP_STR: return K_STR;
      OP_ALU: return au == AL_CMP ? K_CMP : K_ALU;
      OP_MOV: return au == MV_IMM ? K_MOVI : au == MV_REG ? K_MOV : K_ILL;
      OP_HLT: return K_HALT;
      default: return K_ILL;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_seq_mc_cond_eval.sv
// cond_eval: branch condition evaluation on {V,N,Z} with optional extended conditions
module cond_eval
  import ctrl_seq_pkg::*;
#(
  parameter bit EXT_COND = 1'b1
) (
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       take,
  output logic       illegal
);
  logic v, n, z, lt;
  assign {v, n, z} = flags;
  assign lt = n ^ v;
  // Signed less-than is N^V; the rest derive from it and Z
  assign take = cond == C_AL ? 1'b1 :
                cond == C_EQ ? z :
                cond == C_NE ? !z :
                cond == C_LT ? lt :
                cond == C_LE ? z | lt :
                cond == C_GE ? !lt :
                cond == C_GT ? !z & !lt : 1'b0;
  assign illegal = !EXT_COND && (cond == C_GE || cond == C_GT || cond == C_NV);
endmodule

// File: rtl/ctrl_seq_mc.sv
// ctrl_seq_mc: multi-cycle RRISC control sequencer with memory handshake, halt and trap
module ctrl_seq_mc
  import ctrl_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter bit EXT_COND    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] aluop,
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  input  logic       mem_ready,
  input  logic       resume,
  output logic       loadab,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic [1:0] nsel_rd,
  output logic [1:0] nsel_wr,
  output logic       addr_sel,
  output logic       load_addr,
  output logic       load_pc,
  output logic [1:0] pc_src,
  output logic       load_ir,
  output logic [1:0] mem_cmd,
  output logic       strsel,
  output logic       halt,
  output logic       trap
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  state_e state, next;
  op_e kind;
  logic [CNT_W-1:0] cnt;
  logic take, c_ill, dec_x, waiting, timeout, link;
  cond_eval #(.EXT_COND(EXT_COND)) u_cond (
    .cond(cond),
    .flags(flags),
    .take(take),
    .illegal(c_ill)
  );
  assign kind = classify(opcode, aluop);
  assign link = kind == K_BL || kind == K_BLX;
  assign dec_x = $isunknown({opcode, aluop, cond, flags});
  assign waiting = (state == S_FETCH || state == S_MEM) && !mem_ready;
  assign timeout = waiting && cnt == CNT_W'(MEM_TIMEOUT - 1);
  // State register; wait counter runs only while a memory access is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= waiting && !timeout ? cnt + 1'b1 : '0;
    end
  end
  // Next-state dispatch and Moore strobes for the current state
  always_comb begin
    next = state;
    loadab = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    write = 1'b0;
    asel = 1'b0;
    bsel = 1'b0;
    vsel = V_MDATA;
    nsel_rd = 2'd0;
    nsel_wr = 2'd0;
    addr_sel = 1'b0;
    load_addr = 1'b0;
    load_pc = 1'b0;
    pc_src = PC_INC;
    load_ir = 1'b0;
    mem_cmd = MEM_NONE;
    strsel = 1'b0;
    halt = 1'b0;
    trap = 1'b0;
    case (state)
      S_RESET: begin
        load_pc = 1'b1;
        pc_src = PC_RST;
        next = S_FETCH;
      end
      S_FETCH: begin
        addr_sel = 1'b1;
        mem_cmd = MEM_READ;
        next = mem_ready ? S_LOADIR : timeout ? S_TRAP : S_FETCH;
      end
      S_LOADIR: begin
        load_ir = 1'b1;
        load_pc = 1'b1;
        next = S_DECODE;
      end
      S_DECODE: begin
        loadab = 1'b1;
        nsel_rd = kind == K_STR ? 2'd1 : 2'd0;
        next = dec_x ? S_TRAP :
               kind == K_HALT ? S_HALT :
               kind == K_MOVI || link ? S_WB :
               kind inside {K_ALU, K_CMP, K_MOV, K_LDR, K_STR} ? S_EXEC :
               kind == K_B ? (c_ill ? S_TRAP : take ? S_BRANCH : S_FETCH) :
               kind == K_BX ? S_BRANCH : S_TRAP;
      end
      S_EXEC: begin
        loadc = kind != K_CMP;
        loads = kind == K_CMP;
        asel = kind == K_MOV;
        bsel = kind == K_LDR || kind == K_STR;
        next = kind == K_CMP ? S_FETCH : kind == K_LDR || kind == K_STR ? S_MEMADDR : S_WB;
      end
      S_MEMADDR: begin
        load_addr = 1'b1;
        next = S_MEM;
      end
      S_MEM: begin
        mem_cmd = kind == K_STR ? MEM_WRITE : MEM_READ;
        strsel = kind == K_STR;
        next = mem_ready ? (kind == K_LDR ? S_WB : S_FETCH) : timeout ? S_TRAP : S_MEM;
      end
      S_WB: begin
        write = 1'b1;
        vsel = kind == K_MOVI ? V_IMM8 : kind == K_LDR ? V_MDATA : link ? V_PC : V_C;
        nsel_wr = kind == K_MOVI || link ? 2'd2 : 2'd1;
        next = link ? S_BRANCH : S_FETCH;
      end
      S_BRANCH: begin
        load_pc = 1'b1;
        pc_src = kind == K_BX || kind == K_BLX ? PC_RD : PC_REL;
        nsel_rd = kind == K_BX || kind == K_BLX ? 2'd1 : 2'd0;
        next = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
        next = resume ? S_FETCH : S_HALT;
      end
      S_TRAP: trap = 1'b1;
      default: next = S_TRAP;
    endcase
  end
endmodule

// File: tb/tb_ctrl_seq_mc.sv
// tb_ctrl_seq_mc: directed and randomized checks of the sequencer against a phase-path model
module tb_ctrl_seq_mc;
  typedef struct packed {
    logic loadab, loadc, loads, write, asel, bsel;
    logic [1:0] vsel, nsel_rd, nsel_wr;
    logic addr_sel, load_addr, load_pc;
    logic [1:0] pc_src;
    logic load_ir;
    logic [1:0] mem_cmd;
    logic strsel, halt, trap;
  } outs_t;
  localparam int P_RST = 0, P_FE = 1, P_LI = 2, P_DE = 3, P_EX = 4, P_MA = 5;
  localparam int P_ME = 6, P_WB = 7, P_BR = 8, P_HA = 9, P_TR = 10;
  localparam int K_ALU = 0, K_CMP = 1, K_MOV = 2, K_MOVI = 3, K_LDR = 4, K_STR = 5;
  localparam int K_B = 6, K_BL = 7, K_BLX = 8, K_BX = 9, K_HALT = 10, K_ILL = 11;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0, resume = 1'b0;
  logic [2:0] opcode = '0, cond = '0, flags = '0;
  logic [1:0] aluop = '0;
  logic loadab, loadc, loads, write, asel, bsel, addr_sel, load_addr, load_pc, load_ir;
  logic strsel, halt, trap;
  logic [1:0] vsel, nsel_rd, nsel_wr, pc_src, mem_cmd;
  wire [22:0] o0;
  outs_t obs;
  int tests = 0, fails = 0, cyc = 0, li_at = 0;
  always #5 clk = ~clk;
  ctrl_seq_mc #(.MEM_TIMEOUT(4), .EXT_COND(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .aluop(aluop), .cond(cond), .flags(flags),
    .mem_ready(mem_ready), .resume(resume), .loadab(loadab), .loadc(loadc), .loads(loads),
    .write(write), .asel(asel), .bsel(bsel), .vsel(vsel), .nsel_rd(nsel_rd),
    .nsel_wr(nsel_wr), .addr_sel(addr_sel), .load_addr(load_addr), .load_pc(load_pc),
    .pc_src(pc_src), .load_ir(load_ir), .mem_cmd(mem_cmd), .strsel(strsel), .halt(halt),
    .trap(trap)
  );
  ctrl_seq_mc #(.MEM_TIMEOUT(15), .EXT_COND(1'b0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .aluop(aluop), .cond(cond), .flags(flags),
    .mem_ready(mem_ready), .resume(resume), .loadab(o0[0]), .loadc(o0[1]), .loads(o0[2]),
    .write(o0[3]), .asel(o0[4]), .bsel(o0[5]), .vsel(o0[7:6]), .nsel_rd(o0[9:8]),
    .nsel_wr(o0[11:10]), .addr_sel(o0[12]), .load_addr(o0[13]), .load_pc(o0[14]),
    .pc_src(o0[16:15]), .load_ir(o0[17]), .mem_cmd(o0[19:18]), .strsel(o0[20]),
    .halt(o0[21]), .trap(o0[22])
  );
  assign obs = {loadab, loadc, loads, write, asel, bsel, vsel, nsel_rd, nsel_wr, addr_sel,
                load_addr, load_pc, pc_src, load_ir, mem_cmd, strsel, halt, trap};
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic int kind_of(input logic [2:0] op, input logic [1:0] au);
    logic [4:0] e;
    e = {op, au};
    if (op == 3'b111) return K_HALT;
    if (e == 5'b11010) return K_MOVI;
    if (e == 5'b11000) return K_MOV;
    if (op == 3'b101) return au == 2'b01 ? K_CMP : K_ALU;
    if (op == 3'b011) return K_LDR;
    if (op == 3'b100) return K_STR;
    if (op == 3'b001) return K_B;
    if (e == 5'b01011) return K_BL;
    if (e == 5'b01010) return K_BLX;
    if (e == 5'b01000) return K_BX;
    return K_ILL;
  endfunction
  function automatic bit taken(input logic [2:0] c, input logic [2:0] f);
    bit v, n, z;
    {v, n, z} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n != v;
      3'd4: return z || (n != v);
      3'd5: return n == v;
      3'd6: return !z && (n == v);
      default: return 1'b0;
    endcase
  endfunction
  function automatic outs_t expect_of(input int ph, input int k);
    outs_t e;
    e = '0;
    case (ph)
      P_RST: begin e.load_pc = 1; e.pc_src = 2'd1; end
      P_FE: begin e.addr_sel = 1; e.mem_cmd = 2'd1; end
      P_LI: begin e.load_ir = 1; e.load_pc = 1; end
      P_DE: begin e.loadab = 1; e.nsel_rd = (k == K_STR) ? 2'd1 : 2'd0; end
      P_EX: begin
        e.loads = k == K_CMP;
        e.loadc = k != K_CMP;
        e.asel = k == K_MOV;
        e.bsel = k == K_LDR || k == K_STR;
      end
      P_MA: e.load_addr = 1;
      P_ME: begin
        e.mem_cmd = (k == K_LDR) ? 2'd1 : 2'd2;
        e.strsel = k == K_STR;
      end
      P_WB: begin
        e.write = 1;
        if (k == K_MOVI) begin e.vsel = 2'd1; e.nsel_wr = 2'd2; end
        else if (k == K_LDR) begin e.vsel = 2'd0; e.nsel_wr = 2'd1; end
        else if (k == K_BL || k == K_BLX) begin e.vsel = 2'd2; e.nsel_wr = 2'd2; end
        else begin e.vsel = 2'd3; e.nsel_wr = 2'd1; end
      end
      P_BR: begin
        e.load_pc = 1;
        e.pc_src = (k == K_BX || k == K_BLX) ? 2'd3 : 2'd2;
        e.nsel_rd = (k == K_BX || k == K_BLX) ? 2'd1 : 2'd0;
      end
      P_HA: e.halt = 1;
      default: e.trap = 1;
    endcase
    return e;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input outs_t e);
    #1;
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, e);
    end
  endtask
  task automatic chk_v(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    chk("reset", expect_of(P_RST, K_ILL));
    reset = 0;
    tick();
  endtask
  // Runs one instruction starting in FETCH; the phase path is derived from the instruction class
  task automatic run_instr(input logic [2:0] op, input logic [1:0] au, input logic [2:0] c,
                           input logic [2:0] f, input int fw, input int mw, input int hw);
    int k, ph;
    int path[$];
    opcode = op; aluop = au; cond = c; flags = f;
    k = kind_of(op, au);
    path = '{P_FE, P_LI, P_DE};
    case (k)
      K_ALU, K_MOV: path = {path, P_EX, P_WB};
      K_CMP: path.push_back(P_EX);
      K_LDR: path = {path, P_EX, P_MA, P_ME, P_WB};
      K_STR: path = {path, P_EX, P_MA, P_ME};
      K_MOVI: path.push_back(P_WB);
      K_B: if (taken(c, f)) path.push_back(P_BR);
      K_BL, K_BLX: path = {path, P_WB, P_BR};
      K_BX: path.push_back(P_BR);
      K_HALT: path.push_back(P_HA);
      default: path.push_back(P_TR);
    endcase
    foreach (path[i]) begin
      ph = path[i];
      if (ph == P_FE || ph == P_ME) begin
        for (int w = 0; w <= (ph == P_FE ? fw : mw); w++) begin
          mem_ready = w == (ph == P_FE ? fw : mw);
          chk($sformatf("mem ph%0d k%0d w%0d", ph, k, w), expect_of(ph, k));
          tick();
        end
      end else if (ph == P_HA) begin
        resume = 0;
        for (int h = 0; h < hw; h++) begin
          mem_ready = 1'($urandom);
          chk($sformatf("halt hold %0d", h), expect_of(P_HA, k));
          tick();
        end
        resume = 1;
        chk("halt resume", expect_of(P_HA, k));
        tick();
      end else if (ph == P_TR) begin
        for (int t = 0; t < 3; t++) begin
          mem_ready = 1'($urandom);
          chk($sformatf("trap k%0d t%0d", k, t), expect_of(P_TR, k));
          tick();
        end
        do_reset();
      end else begin
        mem_ready = 1'($urandom);
        resume = 1'($urandom);
        if (ph == P_LI) li_at = cyc;
        chk($sformatf("ph%0d op%0b_%0b c%0d f%0b", ph, op, au, c, f), expect_of(ph, k));
        tick();
      end
    end
  endtask
  initial begin
    logic [7:0] ltab [8];
    int lat [7];
    int prev;
    ltab = '{8'b101_00_000, 8'b101_01_000, 8'b011_00_000, 8'b100_00_000,
             8'b001_00_000, 8'b001_00_111, 8'b010_11_000, 8'b101_00_000};
    lat = '{5, 4, 7, 6, 4, 3, 5};
    do_reset();
    // Extended conditions disabled in dut0: LE is legal, GT traps
    run_instr(3'b001, 2'b00, 3'b100, 3'b001, 0, 0, 0);
    chk_v("ext0 le no trap", int'(o0[22]), 0);
    run_instr(3'b001, 2'b00, 3'b110, 3'b000, 0, 0, 0);
    chk_v("ext0 gt trap", int'(o0[22]), 1);
    do_reset();
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      run_instr(ltab[i][7:5], ltab[i][4:3], ltab[i][2:0], 3'b000, 0, 0, 0);
      if (i > 0) chk_v($sformatf("latency %0d", i - 1), li_at - prev, lat[i-1]);
      prev = li_at;
    end
    run_instr(3'b011, 2'b00, 3'b000, 3'b000, 1, 3, 0);
    run_instr(3'b100, 2'b00, 3'b000, 3'b000, 3, 3, 0);
    opcode = 3'b011; aluop = 2'b00;
    mem_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    mem_ready = 0;
    chk("mid mem wait", expect_of(P_ME, K_LDR));
    tick();
    reset = 1;
    tick();
    chk("reset mid mem", expect_of(P_RST, K_LDR));
    reset = 0;
    tick();
    chk("fetch after reset", expect_of(P_FE, K_LDR));
    mem_ready = 0;
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("timeout wait %0d", w), expect_of(P_FE, K_LDR));
      tick();
    end
    for (int t = 0; t < 6; t++) begin
      mem_ready = 1;
      resume = 1;
      chk($sformatf("timeout trap %0d", t), expect_of(P_TR, K_LDR));
      tick();
    end
    do_reset();
    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 8; f++)
        run_instr(3'b001, 2'b00, 3'(c), 3'(f), 0, 0, 0);
    run_instr(3'b010, 2'b10, 3'b000, 3'b000, 0, 0, 0);
    run_instr(3'b010, 2'b00, 3'b000, 3'b000, 0, 0, 0);
    run_instr(3'b110, 2'b10, 3'b000, 3'b000, 0, 0, 0);
    run_instr(3'b110, 2'b00, 3'b000, 3'b000, 0, 0, 0);
    run_instr(3'b111, 2'b01, 3'b000, 3'b000, 0, 0, 10);
    chk("fetch after resume", expect_of(P_FE, K_HALT));
    for (int n = 0; n < 150; n++)
      run_instr(3'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
